// File: rtl/ir_nec_rx_param_pkg.sv
// Shared definitions for the parametrised NEC IR receiver:
// FSM states, nominal pulse widths and tolerance-window helpers.
package ir_nec_rx_param_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_M,
        LEAD_S,
        BIT_M,
        BIT_S,
        STOP_M,
        RPT_M
    } state_t;

    localparam int NOM_LEAD_M = 9000;
    localparam int NOM_LEAD_S = 4500;
    localparam int NOM_RPT_S  = 2250;
    localparam int NOM_BIT_M  = 560;
    localparam int NOM_ZERO_S = 560;
    localparam int NOM_ONE_S  = 1690;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
    } win_t;

    function automatic win_t win_of(input int nom, input int tol);
        win_t r;
        r.lo = 16'(nom * (100 - tol) / 100);
        r.hi = 16'(nom * (100 + tol) / 100);
        return r;
    endfunction

    function automatic logic in_win(input logic [15:0] v, input win_t r);
        return (v >= r.lo) && (v <= r.hi);
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// 1 us enable generator: one-clk-wide tick every CLK_HZ/1_000_000 clocks.
module ir_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int CW  = $clog2(DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/ir_nec_rx_param.sv
// NEC IR receiver: synchroniser, 1 us width counter, frame FSM with
// windowed pulse checks, repeat-code detection and timeout reporting.
module ir_nec_rx_param
    import ir_nec_rx_param_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DATA_BITS  = 32,
    parameter int TOL_PCT    = 20,
    parameter int RX_INV     = 1,
    parameter int TIMEOUT_US = 12000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_ir_rxb,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_repeat,
    output logic                 o_err,
    output logic                 o_chk_ok,
    output logic                 o_busy
);

    localparam logic        INV    = (RX_INV != 0);
    localparam win_t        W_LM   = win_of(NOM_LEAD_M, TOL_PCT);
    localparam win_t        W_LS   = win_of(NOM_LEAD_S, TOL_PCT);
    localparam win_t        W_RS   = win_of(NOM_RPT_S, TOL_PCT);
    localparam win_t        W_BM   = win_of(NOM_BIT_M, TOL_PCT);
    localparam win_t        W_ZS   = win_of(NOM_ZERO_S, TOL_PCT);
    localparam win_t        W_OS   = win_of(NOM_ONE_S, TOL_PCT);
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_US);
    localparam logic [5:0]  NBITS  = 6'(DATA_BITS);

    logic tick;

    ir_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    logic [1:0]  sync;
    logic        mark, mark_q, rise, fall;
    logic [15:0] width;

    // Sync flops reset to the idle pin level so reset release makes no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= {2{INV}};
            mark_q <= 1'b0;
        end else begin
            sync   <= {sync[0], i_ir_rxb};
            mark_q <= mark;
        end
    end

    assign mark = sync[1] ^ INV;
    assign rise = mark & ~mark_q;
    assign fall = ~mark & mark_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width <= '0;
        end else if (rise || fall) begin
            width <= '0;
        end else if (tick && width != 16'hFFFF) begin
            width <= width + 16'd1;
        end
    end

    state_t                 state, state_d;
    logic [DATA_BITS-1:0]   shreg, shreg_d, data_d;
    logic [5:0]             bitcnt, bitcnt_d;
    logic                   seen, seen_d;
    logic                   chk, chk_d, valid_d, rpt_d, err_d;
    logic                   bad, timeout;

    if (DATA_BITS == 32) begin : g_chk32
        assign chk = (shreg[23:16] == ~shreg[31:24]);
    end else begin : g_chk_any
        assign chk = 1'b1;
    end

    assign timeout = (state != IDLE) && (width > TO_LIM);
    assign o_busy  = (state != IDLE);

    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        bitcnt_d = bitcnt;
        seen_d   = seen;
        data_d   = o_data;
        chk_d    = o_chk_ok;
        valid_d  = 1'b0;
        rpt_d    = 1'b0;
        err_d    = 1'b0;
        bad      = 1'b0;
        if (timeout) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE: if (rise) begin
                    state_d  = LEAD_M;
                    bitcnt_d = '0;
                end
                LEAD_M: if (fall) begin
                    if (in_win(width, W_LM)) state_d = LEAD_S;
                    else bad = 1'b1;
                end
                LEAD_S: if (rise) begin
                    if (in_win(width, W_LS)) state_d = BIT_M;
                    else if (in_win(width, W_RS)) state_d = RPT_M;
                    else bad = 1'b1;
                end
                BIT_M: if (fall) begin
                    if (in_win(width, W_BM)) state_d = BIT_S;
                    else bad = 1'b1;
                end
                BIT_S: if (rise) begin
                    if (in_win(width, W_ZS) || in_win(width, W_OS)) begin
                        // Shift right so the first bit ends up at bit 0
                        shreg_d  = {in_win(width, W_OS), shreg[DATA_BITS-1:1]};
                        bitcnt_d = bitcnt + 6'd1;
                        state_d  = (bitcnt_d == NBITS) ? STOP_M : BIT_M;
                    end else begin
                        bad = 1'b1;
                    end
                end
                STOP_M: if (fall) begin
                    if (in_win(width, W_BM)) begin
                        data_d  = shreg;
                        chk_d   = chk;
                        valid_d = 1'b1;
                        seen_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bad = 1'b1;
                    end
                end
                RPT_M: if (fall) begin
                    if (in_win(width, W_BM)) begin
                        rpt_d   = seen;
                        state_d = IDLE;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (bad) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            seen     <= 1'b0;
            o_data   <= '0;
            o_chk_ok <= 1'b0;
            o_valid  <= 1'b0;
            o_repeat <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            bitcnt   <= bitcnt_d;
            seen     <= seen_d;
            o_data   <= data_d;
            o_chk_ok <= chk_d;
            o_valid  <= valid_d;
            o_repeat <= rpt_d;
            o_err    <= err_d;
        end
    end

endmodule
